// File: rtl/trng_pkg.sv
// Shared definitions for the conditioned-entropy buffer reader and the entropy-source wrapper.
package trng_pkg;

    localparam int TRNG_ADDR_W = 10;
    localparam int TRNG_DATA_W = 32;
    localparam int TRNG_WORDS  = 1024;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        WAIT_RDY = 3'd2,
        ISSUE    = 3'd3,
        LAT      = 3'd4,
        HOLD     = 3'd5,
        REARM    = 3'd6
    } trng_state_t;

    // The source is enabled for the whole read window, from arming until the last hold.
    function automatic logic trng_src_enabled(input trng_state_t s);
        return (s == ARM) || (s == WAIT_RDY) || (s == ISSUE) || (s == LAT) || (s == HOLD);
    endfunction

endpackage

// File: rtl/trng_buffer_reader.sv
// Drains the entropy source buffer word by word (address sweep 0..WORDS-1) into a
// valid/ready stream, one batch per start pulse or back-to-back in continuous mode.
module trng_buffer_reader
    import trng_pkg::*;
#(
    parameter int ADDR_W    = TRNG_ADDR_W,
    parameter int DATA_W    = TRNG_DATA_W,
    parameter int WORDS     = TRNG_WORDS,
    parameter int RD_LAT    = 1,
    parameter int REARM_CYC = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              continuous,
    output logic              src_enable,
    input  logic              src_ready,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              err,
    output logic [15:0]       batch_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WORDS - 1);
    localparam logic [2:0]        LAT_LAST   = 3'(RD_LAT - 1);
    localparam logic [15:0]       REARM_LAST = 16'(REARM_CYC - 1);
    localparam logic [31:0]       TMO_LAST   = 32'(TIMEOUT - 1);

    trng_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        lat_q, lat_d;
    logic [15:0]       rearm_q, rearm_d;
    logic [31:0]       tmo_q, tmo_d;
    logic [15:0]       batch_q, batch_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              lost_q, lost_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        rearm_d = rearm_q;
        tmo_d   = tmo_q;
        batch_d = batch_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        err_d   = err_q;
        lost_d  = lost_q;

        case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_d = ARM;
                    tmo_d   = '0;
                end
            end

            // A ready flag still high from an earlier batch is stale; wait for it to drop first.
            ARM: begin
                tmo_d = tmo_q + 32'd1;
                if (!src_ready) begin
                    state_d = WAIT_RDY;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            WAIT_RDY: begin
                tmo_d = tmo_q + 32'd1;
                if (src_ready) begin
                    state_d = ISSUE;
                    addr_d  = '0;
                    lost_d  = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            ISSUE: begin
                lat_d   = '0;
                state_d = LAT;
                if (!src_ready) begin
                    lost_d = 1'b1;
                end
            end

            LAT: begin
                if (!src_ready) begin
                    lost_d = 1'b1;
                end
                if (lat_q == LAT_LAST) begin
                    data_d  = src_data;
                    last_d  = (addr_q == LAST_ADDR);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end

            // A ready drop seen anywhere in the word lets the word finish, then restarts from 0.
            HOLD: begin
                if (m_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = REARM;
                        rearm_d = '0;
                        batch_d = batch_q + 16'd1;
                        lost_d  = 1'b0;
                    end else if (lost_q || !src_ready) begin
                        state_d = ARM;
                        tmo_d   = '0;
                        addr_d  = '0;
                        lost_d  = 1'b0;
                    end else begin
                        state_d = ISSUE;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end else if (!src_ready) begin
                    lost_d = 1'b1;
                end
            end

            REARM: begin
                if (rearm_q == REARM_LAST) begin
                    state_d = continuous ? ARM : IDLE;
                    tmo_d   = '0;
                    addr_d  = '0;
                end else begin
                    rearm_d = rearm_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lat_q   <= '0;
            rearm_q <= '0;
            tmo_q   <= '0;
            batch_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            rearm_q <= rearm_d;
            tmo_q   <= tmo_d;
            batch_q <= batch_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
        end
    end

    assign src_enable = trng_src_enabled(state_q);
    assign src_addr   = addr_q;
    assign m_valid    = valid_q;
    assign m_data     = data_q;
    assign m_last     = last_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign batch_cnt  = batch_q;

endmodule

// File: tb/tb_trng_buffer_reader.sv
// Directed bench for trng_buffer_reader with a 1024x32 source model (word i = 0xA5A50000+i, RD_LAT=1).
module tb_trng_buffer_reader;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int WORDS     = 1024;
    localparam int RD_LAT    = 1;
    localparam int REARM_CYC = 4;
    localparam int TIMEOUT   = 100;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic              src_enable;
    logic              src_ready = 1'b0;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              err;
    logic [15:0]       batch_cnt;

    int vectors = 0;
    int miscompares = 0;

    // 0: ready rises ~20 cycles after enable, 1: forced high, 2: forced low
    int readyMode = 2;
    int enCnt = 0;
    int lowRun = 0;
    int lastLowRun = 0;

    logic [31:0] recvData[$];
    logic        recvLast[$];
    int          stableErr = 0;

    trng_buffer_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS),
        .RD_LAT(RD_LAT), .REARM_CYC(REARM_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
        .src_enable(src_enable), .src_ready(src_ready), .src_addr(src_addr), .src_data(src_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err(err), .batch_cnt(batch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        src_data <= 32'hA5A5_0000 + 32'(src_addr);
        enCnt    <= src_enable ? enCnt + 1 : 0;
        case (readyMode)
            0:       src_ready <= src_enable && (enCnt >= 19);
            1:       src_ready <= 1'b1;
            default: src_ready <= 1'b0;
        endcase
    end

    // Length of the last enable-low gap while busy, recorded when enable comes back.
    always @(negedge clk) begin
        if (busy && !src_enable) begin
            lowRun <= lowRun + 1;
        end else begin
            if (src_enable && lowRun != 0) lastLowRun <= lowRun;
            lowRun <= 0;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Accepts n words with the given ready duty; also counts hold-stability violations.
    task automatic collectWords(input int n, input int dutyPct, input int maxCycles);
        logic        pv, pr, pl, r;
        logic [31:0] pd;
        int          cyc, got;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; cyc = 0; got = 0;
        while (got < n && cyc < maxCycles) begin
            @(negedge clk);
            cyc++;
            if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) stableErr++;
            r = ($urandom_range(0, 99) < dutyPct);
            m_ready = r;
            if (m_valid === 1'b1 && r) begin
                recvData.push_back(m_data);
                recvLast.push_back(m_last);
                got++;
            end
            pv = m_valid; pr = r; pd = m_data; pl = m_last;
        end
    endtask

    task automatic waitIdle(input int maxCycles);
        int cyc;
        cyc = 0;
        while (busy === 1'b1 && cyc < maxCycles) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        readyMode = 2;
        doReset();
        @(negedge clk);
        vectors++; if (src_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_src_enable got %b want 0", src_enable); end
        vectors++; if (src_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_src_addr got %h want 000", src_addr); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_valid got %b want 0", m_valid); end
        vectors++; if (m_data !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_m_data got %h want 00000000", m_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b want 0", err); end
        vectors++; if (batch_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_batch_cnt got %0d want 0", batch_cnt); end
    endtask

    task automatic test_timeout();
        bit sawValid;
        sawValid = 0;
        readyMode = 2;
        pulseStart();
        for (int i = 1; i <= TIMEOUT - 1; i++) begin
            @(negedge clk);
            if (m_valid === 1'b1) sawValid = 1;
        end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_err_early got %b want 0", err); end
        vectors++; if (src_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_enable_wait got %b want 1", src_enable); end
        @(negedge clk);
        if (m_valid === 1'b1) sawValid = 1;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_err got %b want 1", err); end
        vectors++; if (src_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_src_enable got %b want 0", src_enable); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_busy got %b want 0", busy); end
        vectors++; if (sawValid !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_no_valid got %b want 0", sawValid); end
        doReset();
    endtask

    task automatic test_single_batch();
        int badData, badLast, firstBad;
        readyMode = 0;
        recvData.delete(); recvLast.delete();
        pulseStart();
        collectWords(WORDS, 100, 20000);
        badData = 0; badLast = 0; firstBad = -1;
        foreach (recvData[i]) begin
            if (recvData[i] !== 32'hA5A5_0000 + 32'(i)) begin badData++; if (firstBad < 0) firstBad = i; end
            if (recvLast[i] !== (i == WORDS - 1)) badLast++;
        end
        vectors++; if (recvData.size() !== WORDS) begin miscompares++; $display("[TB] FAIL batch_word_count got %0d want %0d", recvData.size(), WORDS); end
        vectors++; if (badData !== 0) begin miscompares++; $display("[TB] FAIL batch_data_order got %0d bad words (first at %0d) want 0", badData, firstBad); end
        vectors++; if (badLast !== 0) begin miscompares++; $display("[TB] FAIL batch_m_last got %0d bad flags want 0", badLast); end
        @(negedge clk);
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL batch_valid_drop got %b want 0", m_valid); end
        vectors++; if (src_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL rearm_src_enable got %b want 0", src_enable); end
        vectors++; if (batch_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL batch_cnt_one got %0d want 1", batch_cnt); end
        repeat (REARM_CYC - 1) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rearm_busy_hold got %b want 1", busy); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rearm_to_idle got %b want 0", busy); end
    endtask

    task automatic test_random_ready();
        int badData;
        readyMode = 0;
        stableErr = 0;
        recvData.delete(); recvLast.delete();
        pulseStart();
        collectWords(WORDS, 30, 40000);
        badData = 0;
        foreach (recvData[i]) begin
            if (recvData[i] !== 32'hA5A5_0000 + 32'(i) || recvLast[i] !== (i == WORDS - 1)) badData++;
        end
        vectors++; if (recvData.size() !== WORDS) begin miscompares++; $display("[TB] FAIL random_word_count got %0d want %0d", recvData.size(), WORDS); end
        vectors++; if (badData !== 0) begin miscompares++; $display("[TB] FAIL random_sequence got %0d bad words want 0", badData); end
        vectors++; if (stableErr !== 0) begin miscompares++; $display("[TB] FAIL random_hold_stable got %0d changes want 0", stableErr); end
        waitIdle(50);
        vectors++; if (batch_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL random_batch_cnt got %0d want 2", batch_cnt); end
    endtask

    task automatic test_stale_ready();
        bit sawValid;
        logic [31:0] first;
        sawValid = 0;
        readyMode = 1;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        pulseStart();
        repeat (30) begin
            @(negedge clk);
            if (m_valid === 1'b1) sawValid = 1;
        end
        vectors++; if (sawValid !== 1'b0) begin miscompares++; $display("[TB] FAIL stale_no_read got %b want 0", sawValid); end
        vectors++; if (src_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL stale_enable got %b want 1", src_enable); end
        readyMode = 2;
        repeat (3) @(negedge clk);
        readyMode = 1;
        recvData.delete(); recvLast.delete();
        collectWords(WORDS, 100, 10000);
        first = (recvData.size() > 0) ? recvData[0] : 32'hxxxx_xxxx;
        vectors++; if (first !== 32'hA5A5_0000) begin miscompares++; $display("[TB] FAIL stale_first_word got %h want a5a50000", first); end
        vectors++; if (recvData.size() !== WORDS) begin miscompares++; $display("[TB] FAIL stale_word_count got %0d want %0d", recvData.size(), WORDS); end
        waitIdle(50);
        vectors++; if (batch_cnt !== 16'd3) begin miscompares++; $display("[TB] FAIL stale_batch_cnt got %0d want 3", batch_cnt); end
        readyMode = 0;
    endtask

    task automatic test_continuous();
        int badData;
        readyMode = 0;
        doReset();
        lastLowRun = 0;
        recvData.delete(); recvLast.delete();
        @(negedge clk);
        continuous = 1'b1;
        collectWords(2 * WORDS + 1, 100, 20000);
        continuous = 1'b0;
        collectWords(WORDS - 1, 100, 20000);
        badData = 0;
        foreach (recvData[i]) begin
            if (recvData[i] !== 32'hA5A5_0000 + 32'(i % WORDS) || recvLast[i] !== ((i % WORDS) == WORDS - 1)) badData++;
        end
        vectors++; if (recvData.size() !== 3 * WORDS) begin miscompares++; $display("[TB] FAIL cont_word_count got %0d want %0d", recvData.size(), 3 * WORDS); end
        vectors++; if (badData !== 0) begin miscompares++; $display("[TB] FAIL cont_sequence got %0d bad words want 0", badData); end
        vectors++; if (lastLowRun !== REARM_CYC) begin miscompares++; $display("[TB] FAIL cont_rearm_gap got %0d want %0d", lastLowRun, REARM_CYC); end
        waitIdle(50);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL cont_idle got %b want 0", busy); end
        vectors++; if (batch_cnt !== 16'd3) begin miscompares++; $display("[TB] FAIL cont_batch_cnt got %0d want 3", batch_cnt); end
    endtask

    task automatic test_reset_midbatch();
        logic [31:0] first;
        readyMode = 0;
        recvData.delete(); recvLast.delete();
        pulseStart();
        collectWords(500, 100, 10000);
        reset_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        vectors++; if (src_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_src_enable got %b want 0", src_enable); end
        vectors++; if (src_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL mid_src_addr got %h want 000", src_addr); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_m_valid got %b want 0", m_valid); end
        vectors++; if (m_data !== 32'd0) begin miscompares++; $display("[TB] FAIL mid_m_data got %h want 00000000", m_data); end
        vectors++; if (m_last !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_m_last got %b want 0", m_last); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy got %b want 0", busy); end
        vectors++; if (batch_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL mid_batch_cnt got %0d want 0", batch_cnt); end
        reset_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL start_with_reset got busy %b want 0", busy); end
        recvData.delete(); recvLast.delete();
        pulseStart();
        collectWords(1, 100, 1000);
        first = (recvData.size() > 0) ? recvData[0] : 32'hxxxx_xxxx;
        vectors++; if (first !== 32'hA5A5_0000) begin miscompares++; $display("[TB] FAIL restart_first_word got %h want a5a50000", first); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_single_batch();
        test_random_ready();
        test_stale_ready();
        test_continuous();
        test_reset_midbatch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
